bus_xfer_ctrl: RTL and testbench

- Bus master (initiator) for the shared tristate register data bus.
- Sequences the per-register select/output-enable/write-enable strobes to move one word per request on that bus.
- Moves are register-to-register, or immediate-to-register with the controller driving the bus itself.
- Sits between the CPU control sequencer and the register file; one transfer in flight at a time.

---
 rtl/bus_xfer_ctrl_if.sv | 38 +++
 rtl/bus_xfer_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_xfer_ctrl_if.sv
// Control-side handshake and strobe bundle for bus_xfer_ctrl.
// The master modport is the controller's view. The slave modport is the view
// of the sequencer and register file.
// The DATA_WIDTH macro overrides the default bus width of 8.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface bus_xfer_ctrl_if #(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned N_REGS     = 4,
  parameter int unsigned SEL_W      = 2
) ();

  logic                  req;
  logic [SEL_W-1:0]      src_sel;
  logic [SEL_W-1:0]      dst_sel;
  logic                  imm_en;
  logic [DATA_WIDTH-1:0] imm_data;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [N_REGS-1:0]     cs;
  logic [N_REGS-1:0]     oe;
  logic [N_REGS-1:0]     en;

  modport master (
    input  req, src_sel, dst_sel, imm_en, imm_data,
    output busy, done, err, cs, oe, en
  );

  modport slave (
    output req, src_sel, dst_sel, imm_en, imm_data,
    input  busy, done, err, cs, oe, en
  );

endinterface

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: initiator for the shared tristate register bus.
// It moves one word per request, either register-to-register or
// immediate-to-register. For immediate moves this block drives the bus.
// Each move runs SRC (settle) -> XFER (destination latches) -> DONE.
// Rejected requests take a single ERR cycle.
// Macros:
//   DATA_WIDTH   -- overrides the default bus width.
//   BUS_SNOOP_EN -- adds snoop_data, which holds the last word transferred.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module bus_xfer_ctrl #(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned N_REGS     = 4,
  parameter int unsigned SEL_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_xfer_ctrl_if.master       ctl,
  inout  wire  [DATA_WIDTH-1:0] data
`ifdef BUS_SNOOP_EN
  ,
  output logic [DATA_WIDTH-1:0] snoop_data
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SRC  = 3'd1,
    ST_XFER = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // One-hot strobe for a register index. Callers only pass indices already
  // known to be in range.
  function automatic logic [N_REGS-1:0] sel_mask(input logic [SEL_W-1:0] sel);
    return N_REGS'(1) << sel;
  endfunction

  // Indices at or above N_REGS are unused encodings when N_REGS < 2**SEL_W.
  function automatic logic in_range(input logic [SEL_W-1:0] sel);
    return 32'(sel) < N_REGS;
  endfunction

  state_e                state_q,  state_d;
  logic [SEL_W-1:0]      src_q,    src_d;
  logic [SEL_W-1:0]      dst_q,    dst_d;
  logic                  imm_en_q, imm_en_d;
  logic [DATA_WIDTH-1:0] imm_q,    imm_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;
  logic                  err_q,    err_d;
  logic [N_REGS-1:0]     cs_q,     cs_d;
  logic [N_REGS-1:0]     oe_q,     oe_d;
  logic [N_REGS-1:0]     en_q,     en_d;
  logic                  drive_q,  drive_d;
  logic                  req_valid_c;

  // A move must name a real destination. A register source must also be real
  // and differ from the destination. The source is don't-care for immediates.
  assign req_valid_c = in_range(ctl.dst_sel) &&
                       (ctl.imm_en ||
                        (in_range(ctl.src_sel) && (ctl.src_sel != ctl.dst_sel)));

  // Next state and next strobe values. Strobes are precomputed here so that
  // the flops present them during the state they belong to.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    imm_en_d = imm_en_q;
    imm_d    = imm_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cs_d     = '0;
    oe_d     = '0;
    en_d     = '0;
    drive_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ctl.req) begin
          if (req_valid_c) begin
            state_d  = ST_SRC;
            src_d    = ctl.src_sel;
            dst_d    = ctl.dst_sel;
            imm_en_d = ctl.imm_en;
            imm_d    = ctl.imm_data;
            busy_d   = 1'b1;
            if (ctl.imm_en) begin
              drive_d = 1'b1;
            end else begin
              cs_d = sel_mask(ctl.src_sel);
              oe_d = sel_mask(ctl.src_sel);
            end
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end

      ST_SRC: begin
        // Keep the source on the bus and open the destination latch.
        state_d = ST_XFER;
        busy_d  = 1'b1;
        if (imm_en_q) begin
          drive_d = 1'b1;
        end else begin
          cs_d = sel_mask(src_q);
          oe_d = sel_mask(src_q);
        end
        cs_d = cs_d | sel_mask(dst_q);
        en_d = sel_mask(dst_q);
      end

      ST_XFER: begin
        state_d = ST_DONE;
        busy_d  = 1'b1;
        done_d  = 1'b1;
      end

      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured request and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cs_q     <= '0;
      oe_q     <= '0;
      en_q     <= '0;
      drive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      imm_en_q <= imm_en_d;
      imm_q    <= imm_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cs_q     <= cs_d;
      oe_q     <= oe_d;
      en_q     <= en_d;
      drive_q  <= drive_d;
    end
  end

`ifdef BUS_SNOOP_EN
  logic [DATA_WIDTH-1:0] snoop_q;

  // Capture the word at the same edge as the destination register does.
  always_ff @(posedge clk) begin
    if (reset) begin
      snoop_q <= '0;
    end else if (state_q == ST_XFER) begin
      snoop_q <= data;
    end
  end

  assign snoop_data = snoop_q;
`endif

  assign ctl.busy = busy_q;
  assign ctl.done = done_q;
  assign ctl.err  = err_q;
  assign ctl.cs   = cs_q;
  assign ctl.oe   = oe_q;
  assign ctl.en   = en_q;

  // Drive the bus only while an immediate is in flight. Otherwise release it.
  assign data = drive_q ? imm_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl.
// A four-entry register file sits on a pulled-up bus, so an undriven bus
// reads as all ones. A transaction-level model expands each request into its
// per-cycle strobe schedule. Every cycle is compared against that schedule,
// and directed tests pin the schedule with literal values.
module tb_bus_xfer_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned SW = 2;

  logic clk = 1'b0;
  logic reset;
  tri1 [DW-1:0] bus;

  bus_xfer_ctrl_if #(.DATA_WIDTH(DW), .N_REGS(NR), .SEL_W(SW)) bif ();

`ifdef BUS_SNOOP_EN
  logic [DW-1:0] snoop_data;
`endif

  bus_xfer_ctrl #(.DATA_WIDTH(DW), .N_REGS(NR), .SEL_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bif),
    .data  (bus)
`ifdef BUS_SNOOP_EN
    ,
    .snoop_data (snoop_data)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- register file on the bus ----------------
  logic [DW-1:0] rf [NR];
  logic          pre_we = 1'b0;
  logic [1:0]    pre_idx = '0;
  logic [DW-1:0] pre_val = '0;
  logic          rf_oe;
  logic [DW-1:0] rf_val;

  always_comb begin
    rf_oe  = 1'b0;
    rf_val = '0;
    for (int i = 0; i < NR; i++) begin
      if (bif.oe[i]) begin
        rf_oe  = 1'b1;
        rf_val = rf[i];
      end
    end
  end

  assign bus = rf_oe ? rf_val : 'z;

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (bif.en[i]) rf[i] <= bus;
    end
    if (pre_we) rf[pre_idx] <= pre_val;
  end

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic          idle;
    logic          busy;
    logic          done;
    logic          err;
    logic [NR-1:0] cs;
    logic [NR-1:0] oe;
    logic [NR-1:0] en;
    logic [DW-1:0] bus;
  } exp_t;

  localparam exp_t IDLE_REC = '{idle: 1'b1, busy: 1'b0, done: 1'b0, err: 1'b0,
                                cs: '0, oe: '0, en: '0, bus: 8'hFF};

  exp_t          cur = IDLE_REC;
  exp_t          sched [$];
  logic [DW-1:0] exp_reg [NR];
  logic [DW-1:0] exp_snoop = '0;
  bit            model_live = 1'b0;

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    exp_t r;
    int   s;
    int   d;
    if (pre_we) exp_reg[pre_idx] = pre_val;
    if (cur.en != '0) begin
      exp_reg[oh_idx(cur.en)] = cur.bus;
      exp_snoop = cur.bus;
    end
    if (reset) begin
      sched.delete();
      cur        = IDLE_REC;
      exp_snoop  = '0;
      model_live = 1'b1;
    end else begin
      if (cur.idle && bif.req) begin
        s = int'(bif.src_sel);
        d = int'(bif.dst_sel);
        if (d < int'(NR) && (bif.imm_en || (s < int'(NR) && s != d))) begin
          r      = IDLE_REC;
          r.idle = 1'b0;
          r.busy = 1'b1;
          if (bif.imm_en) begin
            r.bus = bif.imm_data;
          end else begin
            r.cs  = 4'(1) << s;
            r.oe  = 4'(1) << s;
            r.bus = exp_reg[s];
          end
          sched.push_back(r);
          r.cs = r.cs | (4'(1) << d);
          r.en = 4'(1) << d;
          sched.push_back(r);
          r      = IDLE_REC;
          r.idle = 1'b0;
          r.busy = 1'b1;
          r.done = 1'b1;
          sched.push_back(r);
        end else begin
          r      = IDLE_REC;
          r.idle = 1'b0;
          r.err  = 1'b1;
          sched.push_back(r);
        end
      end
      cur = (sched.size() > 0) ? sched.pop_front() : IDLE_REC;
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (model_live) begin
      chk("cyc_busy", 32'(bif.busy), 32'(cur.busy));
      chk("cyc_done", 32'(bif.done), 32'(cur.done));
      chk("cyc_err",  32'(bif.err),  32'(cur.err));
      chk("cyc_cs",   32'(bif.cs),   32'(cur.cs));
      chk("cyc_oe",   32'(bif.oe),   32'(cur.oe));
      chk("cyc_en",   32'(bif.en),   32'(cur.en));
      chk("cyc_bus",  32'(bus),      32'(cur.bus));
`ifdef BUS_SNOOP_EN
      chk("cyc_snoop", 32'(snoop_data), 32'(exp_snoop));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic preload(input logic [1:0] idx, input logic [DW-1:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_we  = 1'b1;
    @(negedge clk);
    pre_we  = 1'b0;
  endtask

  // Issue one request from a negedge while the DUT is idle. Sample the SRC,
  // XFER and DONE cycles, and record the cycle offsets of done and err.
  task automatic run_xfer(input logic [1:0] s, input logic [1:0] d,
                          input logic ie, input logic [DW-1:0] iv,
                          output logic [NR-1:0] cs1, output logic [NR-1:0] oe1,
                          output logic [NR-1:0] en1, output logic [NR-1:0] cs2,
                          output logic [NR-1:0] oe2, output logic [NR-1:0] en2,
                          output logic [DW-1:0] b1, output logic [DW-1:0] b2,
                          output logic [DW-1:0] b3, output int done_at,
                          output int err_at, output logic strobe_any);
    bif.src_sel  = s;
    bif.dst_sel  = d;
    bif.imm_en   = ie;
    bif.imm_data = iv;
    bif.req      = 1'b1;
    done_at = -1; err_at = -1; strobe_any = 1'b0;
    cs1 = '0; oe1 = '0; en1 = '0; cs2 = '0; oe2 = '0; en2 = '0;
    b1 = '0; b2 = '0; b3 = '0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bif.req = 1'b0;
        cs1 = bif.cs; oe1 = bif.oe; en1 = bif.en; b1 = bus;
      end
      if (n == 2) begin
        cs2 = bif.cs; oe2 = bif.oe; en2 = bif.en; b2 = bus;
      end
      if (n == 3) b3 = bus;
      if (bif.done && done_at < 0) done_at = n;
      if (bif.err && err_at < 0) err_at = n;
      if (|{bif.cs, bif.oe, bif.en}) strobe_any = 1'b1;
    end
  endtask

  logic [NR-1:0] cs1, oe1, en1, cs2, oe2, en2;
  logic [DW-1:0] b1, b2, b3;
  int            done_at, err_at, d1, d2;
  logic          sa;
  bit            saw_done;

  initial begin
    reset        = 1'b1;
    bif.req      = 1'b0;
    bif.src_sel  = '0;
    bif.dst_sel  = '0;
    bif.imm_en   = 1'b0;
    bif.imm_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(bif.busy), 32'd0);
    chk("idle_strobes", 32'({bif.cs, bif.oe, bif.en}), 32'd0);
    chk("idle_bus_z", 32'(bus), 32'hFF);

    preload(2'd0, 8'h00);
    preload(2'd1, 8'hA5);
    preload(2'd2, 8'h77);
    preload(2'd3, 8'h00);

    // Register 1 -> register 3.
    run_xfer(2'd1, 2'd3, 1'b0, 8'h00, cs1, oe1, en1, cs2, oe2, en2, b1, b2, b3, done_at, err_at, sa);
    chk("r2r_src_cs", 32'(cs1), 32'b0010);
    chk("r2r_src_oe", 32'(oe1), 32'b0010);
    chk("r2r_src_en", 32'(en1), 32'b0000);
    chk("r2r_src_bus", 32'(b1), 32'hA5);
    chk("r2r_xfer_cs", 32'(cs2), 32'b1010);
    chk("r2r_xfer_en", 32'(en2), 32'b1000);
    chk("r2r_done_at", 32'(done_at), 32'd3);
    chk("r2r_reg3", 32'(rf[3]), 32'hA5);
`ifdef BUS_SNOOP_EN
    chk("r2r_snoop", 32'(snoop_data), 32'hA5);
`endif

    // Immediate 3C -> register 0. The source select is ignored.
    run_xfer(2'd2, 2'd0, 1'b1, 8'h3C, cs1, oe1, en1, cs2, oe2, en2, b1, b2, b3, done_at, err_at, sa);
    chk("imm_src_oe", 32'(oe1), 32'd0);
    chk("imm_src_cs", 32'(cs1), 32'd0);
    chk("imm_src_bus", 32'(b1), 32'h3C);
    chk("imm_xfer_oe", 32'(oe2), 32'd0);
    chk("imm_xfer_cs", 32'(cs2), 32'b0001);
    chk("imm_xfer_en", 32'(en2), 32'b0001);
    chk("imm_xfer_bus", 32'(b2), 32'h3C);
    chk("imm_done_bus_z", 32'(b3), 32'hFF);
    chk("imm_done_at", 32'(done_at), 32'd3);
    chk("imm_reg0", 32'(rf[0]), 32'h3C);

    // A register source equal to the destination is rejected.
    run_xfer(2'd2, 2'd2, 1'b0, 8'h00, cs1, oe1, en1, cs2, oe2, en2, b1, b2, b3, done_at, err_at, sa);
    chk("err_at", 32'(err_at), 32'd1);
    chk("err_no_done", 32'(done_at), 32'hFFFF_FFFF);
    chk("err_no_strobe", 32'(sa), 32'd0);
    chk("err_reg2", 32'(rf[2]), 32'h77);

    // An immediate whose source select equals the destination is still valid.
    run_xfer(2'd1, 2'd1, 1'b1, 8'h42, cs1, oe1, en1, cs2, oe2, en2, b1, b2, b3, done_at, err_at, sa);
    chk("imm_same_err", 32'(err_at), 32'hFFFF_FFFF);
    chk("imm_same_done", 32'(done_at), 32'd3);
    chk("imm_same_reg1", 32'(rf[1]), 32'h42);

    // Back-to-back requests with req held high.
    bif.imm_en = 1'b1; bif.imm_data = 8'h11; bif.dst_sel = 2'd0; bif.src_sel = 2'd0;
    bif.req = 1'b1;
    d1 = -1; d2 = -1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin bif.dst_sel = 2'd1; bif.imm_data = 8'h22; end
      if (n == 5) bif.req = 1'b0;
      if (bif.done) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
    end
    chk("b2b_done1", 32'(d1), 32'd3);
    chk("b2b_done2", 32'(d2), 32'd7);
    chk("b2b_reg0", 32'(rf[0]), 32'h11);
    chk("b2b_reg1", 32'(rf[1]), 32'h22);

    // Reset asserted during XFER.
    bif.imm_en = 1'b0; bif.src_sel = 2'd3; bif.dst_sel = 2'd2; bif.req = 1'b1;
    saw_done = 1'b0;
    @(negedge clk);
    bif.req = 1'b0;
    @(negedge clk);
    chk("rst_pre_en", 32'(bif.en), 32'b0100);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_strobes", 32'({bif.cs, bif.oe, bif.en}), 32'd0);
    chk("rst_bus_z", 32'(bus), 32'hFF);
    if (bif.done) saw_done = 1'b1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bif.done) saw_done = 1'b1;
    end
    chk("rst_no_done", 32'(saw_done), 32'd0);
    run_xfer(2'd0, 2'd3, 1'b1, 8'h99, cs1, oe1, en1, cs2, oe2, en2, b1, b2, b3, done_at, err_at, sa);
    chk("post_rst_done", 32'(done_at), 32'd3);
    chk("post_rst_reg3", 32'(rf[3]), 32'h99);

    for (int i = 0; i < int'(NR); i++) chk($sformatf("final_reg%0d", i), 32'(rf[i]), 32'(exp_reg[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
